// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: three-stage encoder from a decoded value_sum to a packed posit<32,2>.
// Latency 3 cycles, 1 result per cycle; all stages advance together when the output
// slot is empty or being drained, otherwise the whole pipe holds (in_ready drops).
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       input handshake, in_ready combinational from out_ready
//   in_value                decoded operand (sign, scale, 31-bit extended fraction, inf/zero)
//   out_valid/out_ready     output handshake
//   out_posit               encoded NBITS-bit posit, stable while stalled
//
// Build option: define POSIT_ENC_ROUND_EN for round-to-nearest-even; otherwise the
// guard/sticky bits are dropped (truncation). Saturation applies in both builds.

package posit_defines;
    localparam int NBITS = 32;
    localparam int ES    = 2;
    localparam int FBITS = NBITS - ES - 3;
    localparam int ABITS = FBITS + 4;
    localparam int SBITS = 9;

    typedef struct packed {
        logic                    inf;
        logic                    zero;
        logic                    sign;
        logic signed [SBITS-1:0] scale;
        logic [ES-1:0]           exponent;
        logic [ABITS-1:0]        fraction;
    } value_sum;
endpackage

module posit_encode_pipe
    import posit_defines::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  value_sum         in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_posit
);

    // One extra scale bit so carry/left-normalisation of extreme inputs cannot wrap
    // before the saturation compare.
    localparam int SW   = SBITS + 1;
    localparam int MW   = ABITS - 2;                  // fraction + guard + sticky, hidden dropped
    localparam int XW   = 2 * NBITS;                  // regime-shift work vector
    localparam int PADW = XW - 2 - ES - MW;
    localparam int SAT  = (NBITS - 2) * (1 << ES);    // |scale| beyond this saturates

    logic v1, v2, v3;
    logic adv;

    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    // ---------------- stage 1: normalize ----------------
    logic [4:0]           lzc;
    logic [ABITS-1:0]     frac_shl;
    logic signed [SW-1:0] scale_in;
    logic signed [SW-1:0] n1_scale;
    logic [MW-1:0]        n1_frac;
    logic                 n1_zero;

    // Leading-zero count measured from the hidden-bit position; highest set bit wins.
    always_comb begin
        lzc = '0;
        for (int i = 0; i < ABITS - 1; i++) begin
            if (in_value.fraction[i]) lzc = 5'(ABITS - 2 - i);
        end
    end

    assign frac_shl = in_value.fraction << lzc;
    assign scale_in = {in_value.scale[SBITS-1], in_value.scale};
    assign n1_zero  = in_value.zero | (in_value.fraction == '0);

    always_comb begin
        if (in_value.fraction[ABITS-1]) begin
            // Value >= 2: drop one bit on the right, keeping it alive in sticky.
            n1_frac  = {in_value.fraction[ABITS-2:2], in_value.fraction[1] | in_value.fraction[0]};
            n1_scale = scale_in + SW'(1);
        end else begin
            n1_frac  = frac_shl[MW-1:0];
            n1_scale = scale_in - {{(SW-5){1'b0}}, lzc};
        end
    end

    logic                 s1_sign, s1_inf, s1_zero;
    logic signed [SW-1:0] s1_scale;
    logic [MW-1:0]        s1_frac;

    // ---------------- stage 2: regime / exponent ----------------
    logic signed [SW-1:0] k;
    logic [SW-1:0]        shamt;
    logic signed [XW-1:0] x, y;
    logic [NBITS-2:0]     n2_body;
    logic                 n2_guard, n2_sticky;
    logic                 sat_hi, sat_lo;

    assign k      = s1_scale >>> ES;
    assign shamt  = k[SW-1] ? ~k : k;                 // -k-1 for negative regimes
    assign sat_hi = s1_scale > SAT;
    assign sat_lo = s1_scale < -SAT;

    // Seed "10" (k>=0) or "01" (k<0) above the exponent and fraction; an arithmetic
    // shift then replicates the leading regime bit to the right run length.
    always_comb begin
        x = {(k[SW-1] ? 2'b01 : 2'b10), s1_scale[ES-1:0], s1_frac, {PADW{1'b0}}};
        y = x >>> shamt;
        if (sat_hi) begin
            n2_body   = '1;
            n2_guard  = 1'b0;
            n2_sticky = 1'b0;
        end else if (sat_lo) begin
            n2_body   = {{(NBITS-2){1'b0}}, 1'b1};
            n2_guard  = 1'b0;
            n2_sticky = 1'b0;
        end else begin
            n2_body   = y[XW-1 -: NBITS-1];
            n2_guard  = y[XW-NBITS];
            n2_sticky = |y[XW-NBITS-1:0];
        end
    end

    logic             s2_sign, s2_inf, s2_zero;
    logic [NBITS-2:0] s2_body;
    logic             s2_guard, s2_sticky;

    // ---------------- stage 3: round and pack ----------------
    logic             round_up;
    logic [NBITS-1:0] sum, mag, n3_posit;

`ifdef POSIT_ENC_ROUND_EN
    assign round_up = s2_guard & (s2_body[0] | s2_sticky);
`else
    logic unused_round;
    assign round_up     = 1'b0;
    assign unused_round = s2_guard ^ s2_sticky;
`endif

    always_comb begin
        sum = {1'b0, s2_body} + {{(NBITS-1){1'b0}}, round_up};
        // A round carry out of the body would reach the sign position: clamp to maxpos.
        mag = sum[NBITS-1] ? {1'b0, {(NBITS-1){1'b1}}} : sum;
        if (s2_inf)       n3_posit = {1'b1, {(NBITS-1){1'b0}}};
        else if (s2_zero) n3_posit = '0;
        else if (s2_sign) n3_posit = -mag;
        else              n3_posit = mag;
    end

    logic unused_bits;
    assign unused_bits = ^{in_value.exponent, frac_shl[ABITS-1:MW]};

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            s1_sign   <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_scale  <= '0;
            s1_frac   <= '0;
            s2_sign   <= 1'b0;
            s2_inf    <= 1'b0;
            s2_zero   <= 1'b0;
            s2_body   <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            out_posit <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            s1_sign   <= in_value.sign;
            s1_inf    <= in_value.inf;
            s1_zero   <= n1_zero;
            s1_scale  <= n1_scale;
            s1_frac   <= n1_frac;
            s2_sign   <= s1_sign;
            s2_inf    <= s1_inf;
            s2_zero   <= s1_zero;
            s2_body   <= n2_body;
            s2_guard  <= n2_guard;
            s2_sticky <= n2_sticky;
            out_posit <= n3_posit;
        end
    end

endmodule

// File: tb/tb_posit_encode_pipe.sv
module tb_posit_encode_pipe;
    import posit_defines::*;

`ifdef POSIT_ENC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    value_sum    in_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_posit;

    always #5 clk = ~clk;

    posit_encode_pipe dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    typedef struct {
        logic [31:0] exp;
        int          t_acc;
        bit          lat;
    } sb_t;

    sb_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] cur_exp;
    bit          check_lat = 1'b1;
    bit          hold_vld = 1'b0;
    logic [31:0] hold_val;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard push on input transfer, pop/compare on output transfer.
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid && in_ready) exp_q.push_back('{cur_exp, cyc, check_lat});
            if (out_valid) begin
                if (hold_vld) chk("hold_stable", out_posit, hold_val);
                if (!out_ready) begin
                    chk("in_ready_during_hold", {31'b0, in_ready}, 32'd0);
                    hold_vld = 1'b1;
                    hold_val = out_posit;
                end else begin
                    hold_vld = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h, expected no output", out_posit);
                    end else begin
                        sb_t e;
                        e = exp_q.pop_front();
                        chk("data", out_posit, e.exp);
                        if (e.lat) chk("latency", 32'(cyc - e.t_acc), 32'd3);
                    end
                end
            end else begin
                hold_vld = 1'b0;
            end
        end else begin
            hold_vld = 1'b0;
        end
    end

    function automatic value_sum mk(input bit s, input int sc, input logic [30:0] f,
                                    input bit inf = 1'b0, input bit zero = 1'b0);
        value_sum v;
        v.inf      = inf;
        v.zero     = zero;
        v.sign     = s;
        v.scale    = 9'(sc);
        v.exponent = 2'b11;   // must be ignored
        v.fraction = f;
        return v;
    endfunction

    task automatic send(input value_sum v, input logic [31:0] e);
        int n;
        n = 0;
        in_value = v;
        cur_exp  = e;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0, expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_posit", out_posit, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, back to back.
        send(mk(0, 0, 31'h20000000), 32'h40000000);
        send(mk(1, 0, 31'h20000000), 32'hC0000000);
        send(mk(0, 4, 31'h20000000), 32'h60000000);
        send(mk(0, 0, 31'h40000000), 32'h48000000);
        send(mk(0, 0, 31'h20000002), 32'h40000000);
        send(mk(0, 0, 31'h20000006), RND ? 32'h40000002 : 32'h40000001);
        send(mk(1, 0, 31'h20000006), RND ? 32'hBFFFFFFE : 32'hBFFFFFFF);
        send(mk(0, 0, 31'h3FFFFFFE), RND ? 32'h48000000 : 32'h47FFFFFF);
        send(mk(0, 0, 31'h40000005), RND ? 32'h48000001 : 32'h48000000);
        send(mk(0, -8, 31'h20000005), RND ? 32'h10000001 : 32'h10000000);
        send(mk(0, -1, 31'h20000000), 32'h38000000);
        send(mk(0, 0, 31'h10000000), 32'h38000000);
        send(mk(0, 130, 31'h20000000), 32'h7FFFFFFF);
        send(mk(0, 121, 31'h20000000), 32'h7FFFFFFF);
        send(mk(0, 120, 31'h20000000), 32'h7FFFFFFF);
        send(mk(1, 120, 31'h20000000), 32'h80000001);
        send(mk(0, -120, 31'h20000000), 32'h00000001);
        send(mk(0, -130, 31'h20000000), 32'h00000001);
        send(mk(0, 0, 31'h20000000, 0, 1), 32'h00000000);
        send(mk(1, 0, 31'h00000000), 32'h00000000);
        send(mk(0, 0, 31'h20000000, 1, 0), 32'h80000000);
        send(mk(0, 0, 31'h20000000, 1, 1), 32'h80000000);
        drain();

        // Backpressure: 6 values, out_ready low for 4 cycles after the first output.
        check_lat = 1'b0;
        fork
            begin
                send(mk(0, 0, 31'h20000000), 32'h40000000);
                send(mk(0, 1, 31'h20000000), 32'h48000000);
                send(mk(0, 2, 31'h20000000), 32'h50000000);
                send(mk(0, 3, 31'h20000000), 32'h58000000);
                send(mk(0, 4, 31'h20000000), 32'h60000000);
                send(mk(0, 5, 31'h20000000), 32'h64000000);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_lat = 1'b1;

        // Reset with three values in flight.
        send(mk(0, 0, 31'h20000000), 32'h40000000);
        send(mk(0, 4, 31'h20000000), 32'h60000000);
        send(mk(1, 0, 31'h20000000), 32'hC0000000);
        chk("inflight_valid", {31'b0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_drops_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_clears_posit", out_posit, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(mk(0, -1, 31'h20000000), 32'h38000000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
